// File: rtl/wav_mcu_irq_fast_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wav_mcu_irq_fast_ctrl : per-bit sync / edge / sticky / mask for irq_fast_i
// Revision: 1.0
// ---------------------------------------------------------------------------
module wav_mcu_irq_fast_ctrl #(
  parameter int NUM_IRQ = 15
) (
  input  logic               i_hclk,
  input  logic               i_hreset,
  input  logic [NUM_IRQ-1:0] i_irq_fast,
  input  logic [NUM_IRQ-1:0] i_clr_cfg,
  input  logic [NUM_IRQ-1:0] i_sticky_cfg,
  input  logic [NUM_IRQ-1:0] i_msk_cfg,
  input  logic [NUM_IRQ-1:0] i_sync_cfg,
  input  logic [NUM_IRQ-1:0] i_edge_cfg,
  output logic [NUM_IRQ-1:0] o_irq_fast,
  output logic               o_irq_any,
  output logic [NUM_IRQ-1:0] o_irq_fast_sta
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] hist_q,  hist_d;
  logic [NUM_IRQ-1:0] pend_q,  pend_d;
  logic               any_q,   any_d;

  logic [NUM_IRQ-1:0] w_src;
  logic [NUM_IRQ-1:0] w_ev;
  logic [NUM_IRQ-1:0] w_masked;

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      any_q   <= any_d;
    end
  end

  always_comb begin
    // The chain runs unconditionally so switching sync_cfg sees settled data.
    sync1_d  = i_irq_fast;
    sync2_d  = sync1_q;
    w_src    = (i_sync_cfg & sync2_q) | (~i_sync_cfg & i_irq_fast);
    hist_d   = w_src;
    w_ev     = (i_edge_cfg & w_src & ~hist_q) | (~i_edge_cfg & w_src);
    // Event has priority over clear so a collision never drops an interrupt.
    pend_d   = (i_sticky_cfg & (w_ev | (pend_q & ~i_clr_cfg))) | (~i_sticky_cfg & w_ev);
    w_masked = pend_q & ~i_msk_cfg;
    any_d    = |w_masked;
  end

  always_comb begin
    o_irq_fast_sta = pend_q;
    o_irq_fast     = w_masked;
    o_irq_any      = any_q;
  end

endmodule
`default_nettype wire
